xor_accum_pipeline: RTL and testbench
=====================================

// Module: xor_accum_pipeline
// PURPOSE
//  Parametrised successor of the 8-bit xor/add scrambler. Delays input samples through a
//  DEPTH-stage line and keeps a running mix register; output is the line tail xor the mix.
//  Adds a valid/ready handshake with backpressure. Sits between a sample source and a sink.
// PARAMETERS
//  WIDTH      8     data width, bits (>=2)
//  DEPTH      1     delay-line stages (>=1); DEPTH=1 matches the legacy 8-bit circuit
//  OFFSET     'h22  constant added to the input sample, mod 2^WIDTH
//  SEED       'h55  mix-register value after reset or soft clear
//  CLEAR_VAL  'h03  delay-line stage value after reset or soft clear
// PORTS
//  clk        in   1      rising-edge clock
//  clear      in   1      asynchronous, active-high reset
//  soft_clr   in   1      synchronous reload, same effect as clear
//  in_data    in   WIDTH  input sample
//  in_valid   in   1      in_data valid
//  in_ready   out  1      block accepts in_data this cycle
//  out_data   out  WIDTH  dly[DEPTH-1] ^ mix (combinational from registers)
//  out_valid  out  1      out_data holds a new result
//  out_ready  in   1      sink takes out_data this cycle
// BEHAVIOUR
//  - Reset (clear=1, async): dly[*]=CLEAR_VAL, mix=SEED, fill=0, out_valid=0.
//    out_data=CLEAR_VAL^SEED (0x56 at defaults). in_ready=1 after reset.
//  - in_ready = out_ready | ~out_valid. accept = in_valid & in_ready.
//  - On accept: dly[0]<=in_data; dly[k]<=dly[k-1];
//    mix<=dly[DEPTH-1] ^ ((in_data+OFFSET) mod 2^WIDTH). The old tail is used and the carry is dropped.
//  - fill: counts accepts and saturates at DEPTH. It is clog2(DEPTH+1) bits wide.
//  - out_valid: set on an accept when fill (pre-update) >= DEPTH-1.
//    Cleared when out_valid & out_ready & ~accept. Held when there is accept plus take.
//  - Latency: one cycle from accept to out_data update. The first out_valid comes on the DEPTH-th accept.
//  - Stall: out_valid=1 & out_ready=0 -> in_ready=0. All registers and out_data are held.
//  - No accept -> registers hold. out_data is stable.
//  - soft_clr=1 at a clock edge: same as reset. It beats a same-cycle accept; that sample is dropped.
//    It beats a same-cycle take.
//  - clear asserted mid-stream: in-flight samples are discarded and out_valid drops at once.
//  - All arithmetic is unsigned, WIDTH bits, and wraps modulo 2^WIDTH.
// CONFIGURATION
//  Macro XOR_ACCUM_PIPELINE_COUNT_EN:
//   defined -> extra port out_count (out, 16). It increments by 1 on each out_valid&out_ready
//     and wraps 0xFFFF->0. It is zeroed by clear and by soft_clr.
//   undefined -> no port and no counter logic. Other behaviour is identical.
// STRUCTURE
//  - Package xor_accum_pkg:
//    - default constants: WIDTH_DEF, DEPTH_DEF, OFFSET_DEF, SEED_DEF, CLEAR_VAL_DEF;
//    - typedef for the fill counter width function.
//  - Sub-module xor_accum_delay_line:
//    - WIDTH x DEPTH shift register with enable (accept) and sync load (soft_clr);
//    - async clear; exposes the tail.
//  - The top level holds the handshake, fill/out_valid logic, the mix register and the optional counter.
// TESTING (WIDTH=8 and DEPTH=1 unless stated)
//  1. Assert clear -> out_valid=0, out_data=0x56, in_ready=1. Hold clear for 3 clocks: no change.
//  2. After release, accept 0x10 with out_ready=1 -> next cycle out_valid=1, mix=0x31, out_data=0x21.
//  3. Wrap: accept 0xF0 after test 2 -> mix = 0x10^0x12 = 0x02, out_data=0xF2 (carry dropped).
//  4. Stall: out_valid=1, out_ready=0, in_valid=1 for 4 cycles -> in_ready=0 and out_data held.
//     Then raise out_ready -> one accept per cycle resumes.
//  5. DEPTH=3: accept 0x01,0x02,0x03 -> out_valid=0 after the first two.
//     After the third: out_valid=1, out_data=0x01^(0x03^0x25)=0x27.
//  6. soft_clr together with in_valid=1 -> sample dropped, out_data=0x56, out_valid=0.
//     With COUNT_EN, out_count=0.
//  7. Assert async clear between edges during streaming -> outputs reset immediately, without waiting for clk.

Source files
------------

// File: rtl/xor_accum_pkg.sv
// ----------------------------------------------------------------------------
// xor_accum_pkg
// Shared defaults and helpers for the xor/add accumulating pipeline.
//   WIDTH_DEF      default data width
//   DEPTH_DEF      default delay-line depth
//   OFFSET_DEF     default constant added to each input sample
//   SEED_DEF       default mix-register value after reset / soft clear
//   CLEAR_VAL_DEF  default delay-line stage value after reset / soft clear
//   fill_width()   bit width of a counter that must hold 0..depth
// ----------------------------------------------------------------------------
package xor_accum_pkg;

    localparam int unsigned WIDTH_DEF     = 8;
    localparam int unsigned DEPTH_DEF     = 1;
    localparam int unsigned OFFSET_DEF    = 'h22;
    localparam int unsigned SEED_DEF      = 'h55;
    localparam int unsigned CLEAR_VAL_DEF = 'h03;

    typedef int unsigned fill_width_t;

    // The fill counter saturates at depth, so it needs clog2(depth+1) bits.
    function automatic fill_width_t fill_width(input int unsigned depth);
        return fill_width_t'($clog2(depth + 1));
    endfunction

endpackage

// File: rtl/xor_accum_delay_line.sv
// ----------------------------------------------------------------------------
// xor_accum_delay_line
// WIDTH x DEPTH shift register. Stage 0 takes the new sample; the tail is the
// oldest stage. Asynchronous clear and synchronous load both put every stage
// at CLEAR_VAL; load has priority over a shift.
// Ports:
//   clk      in   rising-edge clock
//   clear    in   asynchronous active-high reset
//   load_i   in   synchronous reload to CLEAR_VAL
//   en_i     in   shift enable (one accepted sample)
//   d_i      in   sample shifted into stage 0
//   tail_o   out  contents of stage DEPTH-1
// ----------------------------------------------------------------------------
module xor_accum_delay_line
    import xor_accum_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned CLEAR_VAL = CLEAR_VAL_DEF
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] tail_o
);

    localparam logic [WIDTH-1:0] CLEAR_W = WIDTH'(CLEAR_VAL);

    logic [WIDTH-1:0] dly_q [DEPTH];
    logic [WIDTH-1:0] dly_d [DEPTH];

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            dly_d[k] = dly_q[k];
        end
        if (load_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                dly_d[k] = CLEAR_W;
            end
        end else if (en_i) begin
            dly_d[0] = d_i;
            for (int k = 1; k < DEPTH; k++) begin
                dly_d[k] = dly_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            for (int k = 0; k < DEPTH; k++) begin
                dly_q[k] <= CLEAR_W;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                dly_q[k] <= dly_d[k];
            end
        end
    end

    assign tail_o = dly_q[DEPTH-1];

endmodule

// File: rtl/xor_accum_pipeline.sv
// ----------------------------------------------------------------------------
// xor_accum_pipeline
// Delays input samples through a DEPTH-stage line and keeps a running mix
// register. out_data = tail ^ mix. On every accepted sample the mix register
// becomes old_tail ^ (in_data + OFFSET) mod 2^WIDTH.
// Optional feature macro: XOR_ACCUM_PIPELINE_COUNT_EN adds out_count, a 16-bit
// wrapping count of output transfers (out_valid & out_ready).
// Ports:
//   clk        in   rising-edge clock
//   clear      in   asynchronous active-high reset
//   soft_clr   in   synchronous reload, same effect as clear
//   in_data    in   input sample
//   in_valid   in   in_data valid
//   in_ready   out  block accepts in_data this cycle
//   out_data   out  tail ^ mix (combinational from registers)
//   out_valid  out  out_data holds a new result
//   out_ready  in   sink takes out_data this cycle
//   out_count  out  (macro only) output transfer count
// ----------------------------------------------------------------------------
module xor_accum_pipeline
    import xor_accum_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned OFFSET    = OFFSET_DEF,
    parameter int unsigned SEED      = SEED_DEF,
    parameter int unsigned CLEAR_VAL = CLEAR_VAL_DEF
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             soft_clr,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef XOR_ACCUM_PIPELINE_COUNT_EN
    ,
    output logic [15:0]      out_count
`endif
);

    localparam int unsigned      FW       = fill_width(DEPTH);
    localparam logic [FW-1:0]    FILL_MAX = FW'(DEPTH);
    localparam logic [FW-1:0]    FILL_SET = FW'(DEPTH - 1);
    localparam logic [FW-1:0]    FILL_ONE = FW'(1);
    localparam logic [WIDTH-1:0] OFFSET_W = WIDTH'(OFFSET);
    localparam logic [WIDTH-1:0] SEED_W   = WIDTH'(SEED);

    // Handshake: a transfer happens on a side when valid & ready are both high
    // at a rising edge. Input ready only depends on the output side, so a full
    // output register that the sink is taking this cycle can be refilled in
    // the same cycle (one accept per cycle under continuous flow).
    logic accept;
    logic take;

    logic [WIDTH-1:0] tail;
    logic [WIDTH-1:0] mix_q,   mix_d;
    logic [FW-1:0]    fill_q,  fill_d;
    logic             valid_q, valid_d;

    assign in_ready = out_ready | ~valid_q;
    assign accept   = in_valid & in_ready;
    assign take     = valid_q & out_ready;

    xor_accum_delay_line #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .CLEAR_VAL (CLEAR_VAL)
    ) u_delay_line (
        .clk    (clk),
        .clear  (clear),
        .load_i (soft_clr),
        .en_i   (accept),
        .d_i    (in_data),
        .tail_o (tail)
    );

    always_comb begin
        mix_d   = mix_q;
        fill_d  = fill_q;
        valid_d = valid_q;
        if (soft_clr) begin
            // Soft clear wins over any same-cycle accept or take.
            mix_d   = SEED_W;
            fill_d  = '0;
            valid_d = 1'b0;
        end else if (accept) begin
            // Uses the tail as it was before this shift; carry of the add is dropped.
            mix_d = tail ^ (in_data + OFFSET_W);
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FILL_ONE;
            end
            // The DEPTH-th accept is the first one whose result reaches the tail.
            if (fill_q >= FILL_SET) begin
                valid_d = 1'b1;
            end
        end else if (take) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            mix_q   <= SEED_W;
            fill_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            mix_q   <= mix_d;
            fill_q  <= fill_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = tail ^ mix_q;
    assign out_valid = valid_q;

`ifdef XOR_ACCUM_PIPELINE_COUNT_EN
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (soft_clr) begin
            count_d = '0;
        end else if (take) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign out_count = count_q;
`endif

endmodule

// File: tb/tb_xor_accum_pipeline.sv
// ----------------------------------------------------------------------------
// tb_xor_accum_pipeline
// Two instances share one stimulus stream: u0 at DEPTH=1 and u1 at DEPTH=3.
// A behavioural model (history of accepted samples per instance) predicts
// out_data, out_valid and in_ready; a negedge compare process checks both
// instances every cycle, and directed sections pin hand-computed values.
// ----------------------------------------------------------------------------
module tb_xor_accum_pipeline;

    logic       clk = 1'b0;
    logic       clear;
    logic       soft_clr;
    logic [7:0] in_data;
    logic       in_valid;
    logic       out_ready;

    logic       in_ready0, in_ready1;
    logic       ov0, ov1;
    logic [7:0] od0, od1;
`ifdef XOR_ACCUM_PIPELINE_COUNT_EN
    logic [15:0] cnt0, cnt1;
`endif

    int checks   = 0;
    int failures = 0;
    logic check_en = 1'b0;

    always #5 clk = ~clk;

    xor_accum_pipeline u0 (
        .clk       (clk),
        .clear     (clear),
        .soft_clr  (soft_clr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .out_data  (od0),
        .out_valid (ov0),
        .out_ready (out_ready)
`ifdef XOR_ACCUM_PIPELINE_COUNT_EN
        ,
        .out_count (cnt0)
`endif
    );

    xor_accum_pipeline #(.DEPTH(3)) u1 (
        .clk       (clk),
        .clear     (clear),
        .soft_clr  (soft_clr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .out_data  (od1),
        .out_valid (ov1),
        .out_ready (out_ready)
`ifdef XOR_ACCUM_PIPELINE_COUNT_EN
        ,
        .out_count (cnt1)
`endif
    );

    // ------------------------------------------------------------------
    // Behavioural model. hist[i][k] is the sample accepted k accepts ago
    // (CLEAR_VAL if fewer accepts since clear). m_n counts accepts since
    // clear; a result is pending once at least DEPTH samples were accepted
    // and the sink has not taken the latest one.
    // ------------------------------------------------------------------
    logic [7:0]  hist  [2][4];
    logic [7:0]  m_mix [2];
    int          m_n   [2];
    logic        m_ov  [2];
    logic [15:0] m_cnt [2];
    logic        mdl_acc, mdl_take;
    logic [7:0]  mdl_sum;

    function automatic int dep(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] m_out(input int i);
        return hist[i][dep(i)-1] ^ m_mix[i];
    endfunction

    function automatic logic m_rdy(input int i);
        return out_ready | ~m_ov[i];
    endfunction

    task automatic m_reset(input int i);
        for (int k = 0; k < 4; k++) hist[i][k] = 8'h03;
        m_mix[i] = 8'h55;
        m_n[i]   = 0;
        m_ov[i]  = 1'b0;
        m_cnt[i] = 16'h0;
    endtask

    always @(posedge clk or posedge clear) begin
        for (int i = 0; i < 2; i++) begin
            if (clear) begin
                m_reset(i);
            end else begin
                mdl_acc  = in_valid & m_rdy(i);
                mdl_take = m_ov[i] & out_ready;
                if (soft_clr) begin
                    m_reset(i);
                end else begin
                    if (mdl_take) m_cnt[i] = m_cnt[i] + 16'd1;
                    if (mdl_acc) begin
                        mdl_sum  = in_data + 8'h22;
                        m_mix[i] = hist[i][dep(i)-1] ^ mdl_sum;
                        for (int k = 3; k > 0; k--) hist[i][k] = hist[i][k-1];
                        hist[i][0] = in_data;
                        if (m_n[i] < 1000) m_n[i] = m_n[i] + 1;
                        if (m_n[i] >= dep(i)) m_ov[i] = 1'b1;
                    end else if (mdl_take) begin
                        m_ov[i] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("u0_out_data",  {8'h0, od0},       {8'h0, m_out(0)});
            chk("u0_out_valid", {15'h0, ov0},      {15'h0, m_ov[0]});
            chk("u0_in_ready",  {15'h0, in_ready0}, {15'h0, m_rdy(0)});
            chk("u1_out_data",  {8'h0, od1},       {8'h0, m_out(1)});
            chk("u1_out_valid", {15'h0, ov1},      {15'h0, m_ov[1]});
            chk("u1_in_ready",  {15'h0, in_ready1}, {15'h0, m_rdy(1)});
`ifdef XOR_ACCUM_PIPELINE_COUNT_EN
            chk("u0_out_count", cnt0, m_cnt[0]);
            chk("u1_out_count", cnt1, m_cnt[1]);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        clear     = 1'b1;
        soft_clr  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 8'h00;
        step();
        check_en = 1'b1;

        // Reset held for three clocks: nothing moves.
        repeat (3) begin
            chk("rst_valid",    {15'h0, ov0},       16'h0);
            chk("rst_data",     {8'h0, od0},        16'h56);
            chk("rst_in_ready", {15'h0, in_ready0}, 16'h1);
            chk("rst_data_d3",  {8'h0, od1},        16'h56);
            step();
        end
        chk("model_rst_data", {8'h0, m_out(0)}, 16'h56);

        // First accept at DEPTH=1.
        clear     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h10;
        step();
        chk("t2_valid",     {15'h0, ov0}, 16'h1);
        chk("t2_data",      {8'h0, od0},  16'h21);
        chk("t2_model_mix", {8'h0, m_mix[0]}, 16'h31);

        // Add wraps, carry dropped.
        in_data = 8'hF0;
        step();
        chk("t3_data",       {8'h0, od0},      16'hF2);
        chk("t3_model_data", {8'h0, m_out(0)}, 16'hF2);

        // Stall: sink not ready, source keeps offering.
        out_ready = 1'b0;
        in_data   = 8'h77;
        repeat (4) begin
            step();
            chk("stall_in_ready", {15'h0, in_ready0}, 16'h0);
            chk("stall_data",     {8'h0, od0},        16'hF2);
            chk("stall_valid",    {15'h0, ov0},       16'h1);
        end
        out_ready = 1'b1;
        step();
        chk("resume_data1", {8'h0, od0}, 16'h1E);
        in_data = 8'h88;
        step();
        chk("resume_data2", {8'h0, od0}, 16'h55);

        // Soft clear beats a same-cycle accept.
        soft_clr = 1'b1;
        in_data  = 8'hAA;
        step();
        soft_clr = 1'b0;
        chk("sclr_data",     {8'h0, od0},  16'h56);
        chk("sclr_valid",    {15'h0, ov0}, 16'h0);
        chk("sclr_data_d3",  {8'h0, od1},  16'h56);
        chk("sclr_valid_d3", {15'h0, ov1}, 16'h0);
`ifdef XOR_ACCUM_PIPELINE_COUNT_EN
        chk("sclr_count", cnt0, 16'h0);
`endif

        // DEPTH=3 fill.
        in_data = 8'h01;
        step();
        chk("d3_valid1", {15'h0, ov1}, 16'h0);
        in_data = 8'h02;
        step();
        chk("d3_valid2", {15'h0, ov1}, 16'h0);
        in_data = 8'h03;
        step();
        chk("d3_valid3", {15'h0, ov1}, 16'h1);
        chk("d3_data3",  {8'h0, od1},  16'h27);

        // Async clear between edges during streaming.
        repeat (3) begin
            in_data = 8'($urandom_range(0, 255));
            step();
        end
        #1;
        clear = 1'b1;
        #1;
        chk("aclr_valid",    {15'h0, ov0},       16'h0);
        chk("aclr_data",     {8'h0, od0},        16'h56);
        chk("aclr_valid_d3", {15'h0, ov1},       16'h0);
        chk("aclr_data_d3",  {8'h0, od1},        16'h56);
        chk("aclr_in_ready", {15'h0, in_ready1}, 16'h1);
        step();
        clear = 1'b0;

        // Randomized traffic with occasional soft and async clears.
        for (int n = 0; n < 4000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom_range(0, 255));
            soft_clr  = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 399) == 0) begin
                clear = 1'b1;
                #1;
                clear = 1'b0;
            end
            step();
        end
        in_valid  = 1'b0;
        soft_clr  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
